// File: rtl/ahb_read_if.sv
// ahb_read_if
//   Bus bundle between the AHB master bridge and its read-data handler.
//   Signals:
//     state         6       one-hot master FSM state (driven by the master side)
//     HRDATA        DATA_W  AHB read data
//     HREADY        1       AHB transfer-done / wait-state indicator
//     ADDR          ADDR_W  current address-phase address
//     RESPONSE      DATA_W  captured read data (driven by the handler)
//     RESPONSE_ADDR RADDR_W response register slot for RESPONSE
//     REG_ENABLE    1       response register file enable
//     REG_WRITE     1       one-cycle write strobe into RESPONSE_ADDR
//   Modports:
//     master - drives the bus-side inputs, observes the register file outputs
//     slave  - the read handler's view
interface ahb_read_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 26,
  parameter int RADDR_W = 5
);
  logic [5:0]         state;
  logic [DATA_W-1:0]  HRDATA;
  logic               HREADY;
  logic [ADDR_W-1:0]  ADDR;
  logic [DATA_W-1:0]  RESPONSE;
  logic [RADDR_W-1:0] RESPONSE_ADDR;
  logic               REG_ENABLE;
  logic               REG_WRITE;

  modport master (
    output state, HRDATA, HREADY, ADDR,
    input  RESPONSE, RESPONSE_ADDR, REG_ENABLE, REG_WRITE
  );

  modport slave (
    input  state, HRDATA, HREADY, ADDR,
    output RESPONSE, RESPONSE_ADDR, REG_ENABLE, REG_WRITE
  );
endinterface

// File: rtl/ahb_read_handler.sv
// ahb_read_handler
//   Read-data path of the AHB master bridge. Tracks read address phases issued
//   by the master FSM, samples HRDATA in the matching (pipelined) data phase and
//   writes each beat into the local response register file.
//   Ports:
//     HCLK     in  clock, rising edge
//     HRESETn  in  synchronous active-low reset
//     bus      ahb_read_if.slave (state, HRDATA, HREADY, ADDR in;
//              RESPONSE, RESPONSE_ADDR, REG_ENABLE, REG_WRITE out)
//   Configuration:
//     AHB_READ_BYTESWAP_EN - when defined, captured data is byte-reversed
//     before it reaches RESPONSE. Timing and control are unchanged.
module ahb_read_handler #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 26,
  parameter int RADDR_W = 5
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  ahb_read_if.slave    bus
);

  localparam logic [5:0] ST_SBURSTR = 6'b000100;
  localparam logic [5:0] ST_INCRBR  = 6'b010000;

  // RD_IDLE: no read transaction open.
  // RD_DATA: a read address phase was accepted and its data phase is pending.
  // "active" and "pending" coincide: a transaction stays open exactly as long
  // as a data phase is outstanding.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  rd_state_e          st_q, st_next;
  logic [RADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0]  response_q;
  logic [RADDR_W-1:0] response_addr_q;
  logic               reg_enable_q;
  logic               reg_write_q;

  logic               read_req;
  logic               accept;
  logic               capture;
  logic               latch_ptr;
  logic               reg_enable_next;
  logic [DATA_W-1:0]  capture_data;

  // Only the low RADDR_W address bits select a slot.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.ADDR[ADDR_W-1:RADDR_W];

  // Exact compare: non-one-hot encodings never start a read.
  assign read_req = (bus.state == ST_SBURSTR) || (bus.state == ST_INCRBR);
  assign accept   = read_req && bus.HREADY;

  // NOTE: HRESETn is sampled only at the clock edge (synchronous reset), so it
  // is deliberately absent from the sensitivity list.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) st_q <= RD_IDLE;
    else          st_q <= st_next;
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    st_next   = st_q;
    capture   = 1'b0;
    latch_ptr = 1'b0;
    unique case (st_q)
      RD_IDLE: begin
        if (accept) begin
          st_next   = RD_DATA;
          latch_ptr = 1'b1;
        end
      end
      RD_DATA: begin
        // HREADY low is a wait state: hold everything. Otherwise the beat is
        // captured, and an overlapping address phase keeps the burst open.
        if (bus.HREADY) begin
          capture = 1'b1;
          st_next = accept ? RD_DATA : RD_IDLE;
        end
      end
      default: st_next = RD_IDLE;
    endcase
  end

  // Enable stays up through the capture edge of the last beat so REG_WRITE is
  // never seen without REG_ENABLE; it falls one cycle later.
  assign reg_enable_next = (st_next == RD_DATA) || capture;

`ifdef AHB_READ_BYTESWAP_EN
  always_comb begin
    capture_data = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      capture_data[8*b +: 8] = bus.HRDATA[DATA_W - 8*(b+1) +: 8];
    end
  end
`else
  assign capture_data = bus.HRDATA;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // here sees the pre-edge values of the others, matching the hardware.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ptr_q           <= '0;
      response_q      <= '0;
      response_addr_q <= '0;
      reg_enable_q    <= 1'b0;
      reg_write_q     <= 1'b0;
    end else begin
      reg_write_q  <= capture;
      reg_enable_q <= reg_enable_next;
      if (latch_ptr) begin
        ptr_q <= bus.ADDR[RADDR_W-1:0];
      end else if (capture) begin
        ptr_q <= ptr_q + 1'b1;  // wraps modulo the slot count
      end
      if (capture) begin
        response_q      <= capture_data;
        response_addr_q <= ptr_q;
      end
    end
  end

  assign bus.RESPONSE      = response_q;
  assign bus.RESPONSE_ADDR = response_addr_q;
  assign bus.REG_ENABLE    = reg_enable_q;
  assign bus.REG_WRITE     = reg_write_q;

endmodule

// File: tb/tb_ahb_read_handler.sv
// tb_ahb_read_handler
//   Directed bench for ahb_read_handler. Inputs change 1 time unit after the
//   rising edge; outputs are checked at that same point, i.e. they reflect the
//   edge just taken.
module tb_ahb_read_handler;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 26;
  localparam int RADDR_W = 5;

  localparam logic [5:0] IDLE    = 6'b000001;
  localparam logic [5:0] SBURSTR = 6'b000100;
  localparam logic [5:0] INCRBR  = 6'b010000;
  localparam logic [5:0] BUSY    = 6'b100000;

  logic HCLK;
  logic HRESETn;

  int checks;
  int failures;

  ahb_read_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RADDR_W(RADDR_W)) bus ();

  ahb_read_handler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RADDR_W(RADDR_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected RESPONSE for a captured HRDATA value.
  function automatic logic [DATA_W-1:0] exp_data(input logic [DATA_W-1:0] d);
`ifdef AHB_READ_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Apply inputs, take one rising edge, land 1 unit after it.
  task automatic step(input logic [5:0] st, input logic [ADDR_W-1:0] addr,
                      input logic rdy, input logic [DATA_W-1:0] data);
    bus.state  = st;
    bus.ADDR   = addr;
    bus.HREADY = rdy;
    bus.HRDATA = data;
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [DATA_W-1:0] resp,
                           input logic [RADDR_W-1:0] raddr, input logic en,
                           input logic wr);
    check({tag, ".RESPONSE"},      64'(bus.RESPONSE),      64'(resp));
    check({tag, ".RESPONSE_ADDR"}, 64'(bus.RESPONSE_ADDR), 64'(raddr));
    check({tag, ".REG_ENABLE"},    64'(bus.REG_ENABLE),    64'(en));
    check({tag, ".REG_WRITE"},     64'(bus.REG_WRITE),     64'(wr));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    HRESETn  = 1'b0;
    bus.state  = IDLE;
    bus.ADDR   = '0;
    bus.HREADY = 1'b0;
    bus.HRDATA = '0;
    @(posedge HCLK);
    #1;

    // Reset with random inputs.
    step(6'($urandom), ADDR_W'($urandom), 1'($urandom), $urandom);
    check_out("reset", 0, 0, 1'b0, 1'b0);
    HRESETn = 1'b1;
    step(IDLE, 0, 1, 32'h1234);
    check_out("post_reset_idle", 0, 0, 1'b0, 1'b0);

    // Single read.
    step(SBURSTR, 1, 1, 0);
    check_out("single.addr", 0, 0, 1'b1, 1'b0);
    step(IDLE, 0, 1, 10);
    check_out("single.data", exp_data(10), 1, 1'b1, 1'b1);
    step(IDLE, 0, 1, 0);
    check_out("single.end", exp_data(10), 1, 1'b0, 1'b0);

    // Address phase offered with HREADY low is not accepted.
    step(SBURSTR, 7, 0, 0);
    step(IDLE, 0, 1, 32'h99);
    check_out("noready", exp_data(10), 1, 1'b0, 1'b0);

    // Wait states in the data phase (new slot to show ptr relatch).
    step(SBURSTR, 6, 1, 0);
    step(IDLE, 0, 0, 0);
    check_out("wait.1", exp_data(10), 1, 1'b1, 1'b0);
    step(IDLE, 0, 0, 0);
    check_out("wait.2", exp_data(10), 1, 1'b1, 1'b0);
    step(IDLE, 0, 1, 32'h0102_0304);
    check_out("wait.data", exp_data(32'h0102_0304), 6, 1'b1, 1'b1);
    step(IDLE, 0, 1, 0);
    check_out("wait.end", exp_data(32'h0102_0304), 6, 1'b0, 1'b0);

    // BUSY after the address phase: one capture only.
    step(SBURSTR, 1, 1, 0);
    step(BUSY, 0, 1, 10);
    check_out("busy.data", exp_data(10), 1, 1'b1, 1'b1);
    step(BUSY, 0, 1, 32'h77);
    check_out("busy.hold", exp_data(10), 1, 1'b0, 1'b0);
    step(IDLE, 0, 1, 32'h88);
    check_out("busy.idle", exp_data(10), 1, 1'b0, 1'b0);

    // Non-one-hot state does not start a read.
    step(6'b010100, 3, 1, 0);
    step(IDLE, 0, 1, 32'h44);
    check_out("nonhot", exp_data(10), 1, 1'b0, 1'b0);

    // Incrementing burst, overlapping phases.
    step(INCRBR, 1, 1, 0);
    check_out("incr.addr", exp_data(10), 1, 1'b1, 1'b0);
    step(INCRBR, 0, 1, 10);
    check_out("incr.beat0", exp_data(10), 1, 1'b1, 1'b1);
    step(IDLE, 0, 1, 20);
    check_out("incr.beat1", exp_data(20), 2, 1'b1, 1'b1);
    step(IDLE, 0, 1, 0);
    check_out("incr.end", exp_data(20), 2, 1'b0, 1'b0);

    // Slot pointer wrap 31 -> 0.
    step(INCRBR, 31, 1, 0);
    step(INCRBR, 0, 1, 32'hA);
    check_out("wrap.beat0", exp_data(32'hA), 31, 1'b1, 1'b1);
    step(IDLE, 0, 1, 32'hB);
    check_out("wrap.beat1", exp_data(32'hB), 0, 1'b1, 1'b1);
    step(IDLE, 0, 1, 0);
    check_out("wrap.end", exp_data(32'hB), 0, 1'b0, 1'b0);

    // Reset while a beat is pending: the beat is dropped.
    step(SBURSTR, 5, 1, 0);
    check_out("rstmid.addr", exp_data(32'hB), 0, 1'b1, 1'b0);
    HRESETn = 1'b0;
    step(IDLE, 0, 1, 32'h33);
    check_out("rstmid.reset", 0, 0, 1'b0, 1'b0);
    HRESETn = 1'b1;
    step(IDLE, 0, 1, 32'h33);
    check_out("rstmid.after", 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
